rf_bypass_mp: RTL and testbench



---
 rtl/rf_bypass_mp.sv | 94 +++++++++
 tb/tb_rf_bypass_mp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_bypass_mp.sv
// Parametrised multi-port register file for the decode stage: two write ports
// (wr1 wins), two combinational read ports with optional same-cycle bypass.
`timescale 1ns/1ps
module rf_bypass_mp #(
  parameter int              WIDTH    = 16,
  parameter int              NREG     = 8,
  parameter int              SELW     = 3,
  parameter int              ZERO_REG = 0,
  parameter int              BYPASS   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SELW-1:0]  rd0_sel,
  input  logic [SELW-1:0]  rd1_sel,
  input  logic             wr0_en,
  input  logic [SELW-1:0]  wr0_sel,
  input  logic [WIDTH-1:0] wr0_data,
  input  logic             wr1_en,
  input  logic [SELW-1:0]  wr1_sel,
  input  logic [WIDTH-1:0] wr1_data,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             err,
  output logic             err_sticky
);

  logic [WIDTH-1:0] regs [NREG];
  logic             wr0_ok, wr1_ok, conflict;

  function automatic logic in_range(input logic [SELW-1:0] s);
    return int'(s) < NREG;
  endfunction

  function automatic logic is_zero_reg(input logic [SELW-1:0] s);
    return (ZERO_REG != 0) && (s == '0);
  endfunction

  // A write is "ok" only if it will actually land; writes to the hardwired
  // zero register are dropped silently and are never forwarded.
  assign wr0_ok   = wr0_en && in_range(wr0_sel) && !is_zero_reg(wr0_sel);
  assign wr1_ok   = wr1_en && in_range(wr1_sel) && !is_zero_reg(wr1_sel);
  assign conflict = wr0_ok && wr1_ok && (wr0_sel == wr1_sel);

  function automatic logic [WIDTH-1:0] read_mux(input logic [SELW-1:0] s);
    logic [WIDTH-1:0] v;
    v = '0;
    if (in_range(s) && !is_zero_reg(s)) begin
      if (BYPASS != 0 && wr1_ok && wr1_sel == s)
        v = wr1_data;
      else if (BYPASS != 0 && wr0_ok && wr0_sel == s)
        v = wr0_data;
      else
        v = regs[s];
    end
    return v;
  endfunction

  always_comb begin
    rd0_data = read_mux(rd0_sel);
    rd1_data = read_mux(rd1_sel);
    err      = (wr0_en && !in_range(wr0_sel)) ||
               (wr1_en && !in_range(wr1_sel)) ||
               conflict ||
               !in_range(rd0_sel) ||
               !in_range(rd1_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= (ZERO_REG != 0 && i == 0) ? '0 : RST_VAL;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr1_ok && int'(wr1_sel) == i)
          regs[i] <= wr1_data;
        else if (wr0_ok && int'(wr0_sel) == i)
          regs[i] <= wr0_data;
      end
    end
  end

  // A new error takes precedence over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_sticky <= 1'b0;
    else if (err)
      err_sticky <= 1'b1;
    else if (err_clr)
      err_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_rf_bypass_mp.sv
// Bench for rf_bypass_mp: three configurations (default, zero-reg/no-bypass/NREG=6,
// 32x32) checked against a reference model through an expectation queue.
`timescale 1ns/1ps
module tb_rf_bypass_mp;

  typedef struct {
    bit          w0e;
    int          w0s;
    logic [31:0] w0d;
    bit          w1e;
    int          w1s;
    logic [31:0] w1d;
    int          r0;
    int          r1;
    bit          clr;
  } in_t;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  in_ab, in_c;

  logic [15:0] a_rd0, a_rd1, b_rd0, b_rd1;
  logic [31:0] c_rd0, c_rd1;
  logic        a_err, a_stk, b_err, b_stk, c_err, c_stk;

  exp_t        sb[$];
  int          vectors = 0;
  int          fails = 0;

  // Reference model state, one row per instance.
  logic [31:0] mdl [3][32];
  bit          stk [3];
  int          nreg [3] = '{8, 6, 32};
  bit          zr   [3] = '{1'b0, 1'b1, 1'b0};
  bit          byp  [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] rstv [3] = '{32'h0, 32'h0000_00A5, 32'hDEAD_0001};
  string       nm   [3] = '{"A", "B", "C"};

  always #5 clk = ~clk;

  rf_bypass_mp u_a (
    .clk(clk), .rst_n(rst_n),
    .rd0_sel(3'(in_ab.r0)), .rd1_sel(3'(in_ab.r1)),
    .wr0_en(in_ab.w0e), .wr0_sel(3'(in_ab.w0s)), .wr0_data(in_ab.w0d[15:0]),
    .wr1_en(in_ab.w1e), .wr1_sel(3'(in_ab.w1s)), .wr1_data(in_ab.w1d[15:0]),
    .err_clr(in_ab.clr),
    .rd0_data(a_rd0), .rd1_data(a_rd1), .err(a_err), .err_sticky(a_stk)
  );

  rf_bypass_mp #(
    .WIDTH(16), .NREG(6), .SELW(3), .ZERO_REG(1), .BYPASS(0), .RST_VAL(16'h00A5)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .rd0_sel(3'(in_ab.r0)), .rd1_sel(3'(in_ab.r1)),
    .wr0_en(in_ab.w0e), .wr0_sel(3'(in_ab.w0s)), .wr0_data(in_ab.w0d[15:0]),
    .wr1_en(in_ab.w1e), .wr1_sel(3'(in_ab.w1s)), .wr1_data(in_ab.w1d[15:0]),
    .err_clr(in_ab.clr),
    .rd0_data(b_rd0), .rd1_data(b_rd1), .err(b_err), .err_sticky(b_stk)
  );

  rf_bypass_mp #(
    .WIDTH(32), .NREG(32), .SELW(5), .ZERO_REG(0), .BYPASS(1), .RST_VAL(32'hDEAD_0001)
  ) u_c (
    .clk(clk), .rst_n(rst_n),
    .rd0_sel(5'(in_c.r0)), .rd1_sel(5'(in_c.r1)),
    .wr0_en(in_c.w0e), .wr0_sel(5'(in_c.w0s)), .wr0_data(in_c.w0d),
    .wr1_en(in_c.w1e), .wr1_sel(5'(in_c.w1s)), .wr1_data(in_c.w1d),
    .err_clr(in_c.clr),
    .rd0_data(c_rd0), .rd1_data(c_rd1), .err(c_err), .err_sticky(c_stk)
  );

  function automatic bit lands(int k, bit en, int s);
    return en && (s < nreg[k]) && !(zr[k] && s == 0);
  endfunction

  function automatic logic [31:0] exp_rd(int k, in_t x, int s);
    if (s >= nreg[k]) return 32'h0;
    if (zr[k] && s == 0) return 32'h0;
    if (byp[k] && lands(k, x.w1e, x.w1s) && x.w1s == s) return x.w1d;
    if (byp[k] && lands(k, x.w0e, x.w0s) && x.w0s == s) return x.w0d;
    return mdl[k][s];
  endfunction

  function automatic bit exp_err(int k, in_t x);
    return (x.w0e && x.w0s >= nreg[k]) || (x.w1e && x.w1s >= nreg[k]) ||
           (lands(k, x.w0e, x.w0s) && lands(k, x.w1e, x.w1s) && x.w0s == x.w1s) ||
           (x.r0 >= nreg[k]) || (x.r1 >= nreg[k]);
  endfunction

  function automatic in_t inputs_of(int k);
    return (k == 2) ? in_c : in_ab;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++)
        mdl[k][i] = (zr[k] && i == 0) ? 32'h0 : rstv[k];
      stk[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      in_t x;
      bit  e;
      x = inputs_of(k);
      e = exp_err(k, x);
      if (e) stk[k] = 1'b1;
      else if (x.clr) stk[k] = 1'b0;
      if (lands(k, x.w0e, x.w0s) && !(lands(k, x.w1e, x.w1s) && x.w1s == x.w0s))
        mdl[k][x.w0s] = x.w0d;
      if (lands(k, x.w1e, x.w1s))
        mdl[k][x.w1s] = x.w1d;
    end
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    e = sb.pop_front();
    vectors++;
    assert (obs === e.exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic check_now();
    for (int k = 0; k < 3; k++) begin
      in_t x;
      x = inputs_of(k);
      sb.push_back('{$sformatf("%s rd0 sel%0d", nm[k], x.r0), exp_rd(k, x, x.r0)});
      sb.push_back('{$sformatf("%s rd1 sel%0d", nm[k], x.r1), exp_rd(k, x, x.r1)});
      sb.push_back('{$sformatf("%s err", nm[k]), {31'b0, exp_err(k, x)}});
      sb.push_back('{$sformatf("%s err_sticky", nm[k]), {31'b0, stk[k]}});
    end
    #1;
    chk(32'(a_rd0)); chk(32'(a_rd1)); chk(32'(a_err)); chk(32'(a_stk));
    chk(32'(b_rd0)); chk(32'(b_rd1)); chk(32'(b_err)); chk(32'(b_stk));
    chk(c_rd0);      chk(c_rd1);      chk(32'(c_err)); chk(32'(c_stk));
  endtask

  task automatic cyc();
    check_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    in_ab = '{default: 0};
    in_c  = '{default: 0};
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_ab.r1 = 1; in_c.r1 = 1;
    cyc();

    // Fill every register with 0x1234 (B sees sel 6/7 as out of range).
    for (int i = 0; i < 8; i++) begin
      idle();
      in_ab.w0e = 1; in_ab.w0s = i; in_ab.w0d = 32'h1234;
      in_ab.r0 = i;  in_ab.r1 = (i + 1) % 8;
      in_c.w0e = 1;  in_c.w0s = i; in_c.w0d = 32'h1234; in_c.r0 = i;
      cyc();
    end

    // Asynchronous reset mid-cycle, no clock edge before the check.
    idle();
    in_ab.r0 = 2; in_ab.r1 = 5; in_c.r0 = 2; in_c.r1 = 5;
    #2 rst_n = 1'b0;
    model_reset();
    check_now();
    // A write held across an edge while in reset must be discarded.
    in_ab.w0e = 1; in_ab.w0s = 2; in_ab.w0d = 32'hBEEF;
    in_c.w0e = 1;  in_c.w0s = 2;  in_c.w0d = 32'hBEEF;
    @(posedge clk);
    @(negedge clk);
    in_ab.w0e = 0; in_c.w0e = 0;
    check_now();
    rst_n = 1'b1;

    // Same-cycle bypass versus stored value.
    idle(); in_ab.w0e = 1; in_ab.w0s = 3; in_ab.w0d = 32'hBEEF; in_ab.r0 = 3; in_ab.r1 = 3;
    cyc();
    idle(); in_ab.r0 = 3; in_ab.r1 = 3; in_ab.w0s = 7;
    cyc();

    // Write-write conflict on r5.
    idle();
    in_ab.w0e = 1; in_ab.w0s = 5; in_ab.w0d = 32'h1111;
    in_ab.w1e = 1; in_ab.w1s = 5; in_ab.w1d = 32'h2222; in_ab.r1 = 5;
    in_c.w0e = 1; in_c.w0s = 9; in_c.w0d = 32'h1111_0000;
    in_c.w1e = 1; in_c.w1s = 9; in_c.w1d = 32'h2222_0000; in_c.r0 = 9;
    cyc();
    idle(); in_ab.r1 = 5; in_c.r0 = 9;
    cyc();

    // Clear, then writes to r0 (hardwired zero in B).
    idle(); in_ab.clr = 1; in_c.clr = 1;
    cyc();
    idle(); in_ab.w0e = 1; in_ab.w0s = 0; in_ab.w0d = 32'hFFFF;
    cyc();
    idle();
    cyc();

    // Two ports to different registers, both read ports on one register.
    idle();
    in_ab.w0e = 1; in_ab.w0s = 1; in_ab.w0d = 32'hAAAA;
    in_ab.w1e = 1; in_ab.w1s = 2; in_ab.w1d = 32'h5555;
    in_ab.r0 = 2; in_ab.r1 = 2;
    cyc();
    idle(); in_ab.r0 = 1; in_ab.r1 = 2;
    cyc();

    // Out-of-range write and read for B, then sticky clear behaviour.
    idle(); in_ab.w1e = 1; in_ab.w1s = 7; in_ab.w1d = 32'h7777; in_ab.r0 = 6;
    cyc();
    idle(); in_ab.clr = 1; in_ab.r0 = 7;
    cyc();
    idle(); in_ab.clr = 1; in_ab.r0 = 4;
    cyc();
    idle(); in_ab.clr = 1; in_ab.w0e = 1; in_ab.w0s = 6; in_ab.w0d = 32'h0666;
    cyc();
    idle();
    cyc();

    // Random two-port traffic on all three instances.
    for (int n = 0; n < 3000; n++) begin
      in_ab.w0e = 1'($urandom_range(0, 1));
      in_ab.w0s = int'($urandom_range(0, 7));
      in_ab.w0d = 32'($urandom_range(0, 16'hFFFF));
      in_ab.w1e = 1'($urandom_range(0, 1));
      in_ab.w1s = ($urandom_range(0, 3) == 0) ? in_ab.w0s : int'($urandom_range(0, 7));
      in_ab.w1d = 32'($urandom_range(0, 16'hFFFF));
      in_ab.r0  = ($urandom_range(0, 2) == 0) ? in_ab.w1s : int'($urandom_range(0, 7));
      in_ab.r1  = ($urandom_range(0, 2) == 0) ? in_ab.w0s : int'($urandom_range(0, 7));
      in_ab.clr = ($urandom_range(0, 3) == 0);
      in_c.w0e  = 1'($urandom_range(0, 1));
      in_c.w0s  = int'($urandom_range(0, 31));
      in_c.w0d  = $urandom;
      in_c.w1e  = 1'($urandom_range(0, 1));
      in_c.w1s  = ($urandom_range(0, 9) == 0) ? in_c.w0s : int'($urandom_range(0, 31));
      in_c.w1d  = $urandom;
      in_c.r0   = ($urandom_range(0, 2) == 0) ? in_c.w1s : int'($urandom_range(0, 31));
      in_c.r1   = ($urandom_range(0, 2) == 0) ? in_c.w0s : int'($urandom_range(0, 31));
      in_c.clr  = ($urandom_range(0, 3) == 0);
      cyc();
    end

    idle();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
